// File: rtl/sysid_read_pkg.sv
// rtl/sysid_read_pkg.sv - shared types and constants for the sysid read master
package sysid_read_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int TIMEOUT_CYCLES_DEFAULT = 256;
  localparam int TIMEOUT_CNT_W_DEFAULT  = $clog2(TIMEOUT_CYCLES_DEFAULT);

  // Counter only ever needs to reach TIMEOUT_CYCLES-1.
  function automatic int timeout_cnt_w(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/sysid_read_master_if.sv
// rtl/sysid_read_master_if.sv - Avalon-MM read port between the master and the sysid slave
interface sysid_read_master_if;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        av_readdatavalid;

  modport master (
    output av_address, av_read,
    input  av_waitrequest, av_readdata, av_readdatavalid
  );

  modport slave (
    input  av_address, av_read,
    output av_waitrequest, av_readdata, av_readdatavalid
  );
endinterface

// File: rtl/sysid_timeout_ctr.sv
// rtl/sysid_timeout_ctr.sv - per-transaction cycle counter flagging expiry at TIMEOUT_CYCLES-1
module sysid_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);
  import sysid_read_pkg::*;

  localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Holds at LAST so a late cycle cannot wrap back under the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);
endmodule

// File: rtl/sysid_read_master.sv
// rtl/sysid_read_master.sv - reads sysid ID and timestamp words and checks them; SYSID_READDATAVALID_EN enables pipelined reads
module sysid_read_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1683891951,
  parameter int          TIMEOUT_CYCLES     = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  sysid_read_master_if.master        av,
  output logic [31:0]                id_value,
  output logic [31:0]                timestamp_value,
  output logic                       busy,
  output logic                       done,
  output logic                       match,
  output logic                       timeout_err
);
  import sysid_read_pkg::*;

`ifdef SYSID_READDATAVALID_EN
  localparam bit PIPELINED = 1'b1;
  logic rdv;
  assign rdv = av.av_readdatavalid;
`else
  localparam bit PIPELINED = 1'b0;
  logic rdv;
  logic unused_rdv;
  assign rdv        = 1'b0;
  assign unused_rdv = av.av_readdatavalid;
`endif

  sysid_state_t state, next_state;

  logic rd_state, wt_state, accept, start_ok, expired;
  logic take_id, take_ts, timeout_hit, ctr_load;

  assign rd_state = (state == RD_ID) || (state == RD_TS);
  assign wt_state = (state == WT_ID) || (state == WT_TS);
  assign accept   = rd_state && !av.av_waitrequest;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Data capture beats expiry in the same cycle.
  assign take_id = PIPELINED ? ((state == WT_ID) && rdv) : ((state == RD_ID) && accept);
  assign take_ts = PIPELINED ? ((state == WT_TS) && rdv) : ((state == RD_TS) && accept);

  assign ctr_load    = start_ok || ((next_state == RD_TS) && (state != RD_TS));
  assign timeout_hit = (rd_state || wt_state) && (next_state == DONE);

  sysid_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .load    (ctr_load),
    .enable  (rd_state || wt_state),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = RD_ID;
      RD_ID: begin
        if (accept)       next_state = PIPELINED ? WT_ID : RD_TS;
        else if (expired) next_state = DONE;
      end
      WT_ID: begin
        if (rdv)          next_state = RD_TS;
        else if (expired) next_state = DONE;
      end
      RD_TS: begin
        if (accept)       next_state = PIPELINED ? WT_TS : CHECK;
        else if (expired) next_state = DONE;
      end
      WT_TS: begin
        if (rdv)          next_state = CHECK;
        else if (expired) next_state = DONE;
      end
      CHECK:   next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    av.av_read    = rd_state;
    av.av_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy          = (state != IDLE) && (state != DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      id_value        <= '0;
      timestamp_value <= '0;
      match           <= 1'b0;
      timeout_err     <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= (next_state == DONE) && (state != DONE);
      if (start_ok) begin
        id_value        <= '0;
        timestamp_value <= '0;
        match           <= 1'b0;
        timeout_err     <= 1'b0;
      end else begin
        if (take_id) id_value        <= av.av_readdata;
        if (take_ts) timestamp_value <= av.av_readdata;
        if (state == CHECK) begin
          match <= (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);
        end
        if (timeout_hit) begin
          timeout_err <= 1'b1;
          match       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sysid_read_master.sv
// tb/tb_sysid_read_master.sv - directed table-driven bench for sysid_read_master
module tb_sysid_read_master;

  localparam int          TO     = 8;
  localparam logic [31:0] EXP_TS = 32'd1683891951;

`ifdef SYSID_READDATAVALID_EN
  localparam int RDV_LAT  = 5;
  localparam int W_MID    = 1;
  localparam int W_EDGE   = 2;
  localparam int W_LAST   = 1;
  localparam int LAT0     = 14;
  localparam int LAT_MID  = 16;
  localparam int LAT_ONE  = 16;
  localparam int LAT_EDGE = 18;
  localparam int LAT_LAST = 16;
`else
  localparam int RDV_LAT  = 0;
  localparam int W_MID    = 3;
  localparam int W_EDGE   = 7;
  localparam int W_LAST   = 2;
  localparam int LAT0     = 4;
  localparam int LAT_MID  = 10;
  localparam int LAT_ONE  = 6;
  localparam int LAT_EDGE = 18;
  localparam int LAT_LAST = 8;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] id_value, timestamp_value;
  logic        busy, done, match, timeout_err;

  sysid_read_master_if bus ();

  sysid_read_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .av              (bus),
    .id_value        (id_value),
    .timestamp_value (timestamp_value),
    .busy            (busy),
    .done            (done),
    .match           (match),
    .timeout_err     (timeout_err)
  );

  always #5 clock = ~clock;

  // Slave model: wait_n stall cycles per read, optional readdatavalid delay.
  logic [31:0] id_word = '0, ts_word = '0;
  int          wait_n = 0;
  logic        stuck = 1'b0, force_rdv = 1'b0;
  int          wait_cnt = 0, pend_cnt = 0;
  logic        pend_addr = 1'b0;
  logic        rd_addr;

  assign bus.av_waitrequest   = bus.av_read && (stuck || (wait_cnt < wait_n));
  assign rd_addr              = bus.av_read ? bus.av_address : pend_addr;
  assign bus.av_readdata      = rd_addr ? ts_word : id_word;
  assign bus.av_readdatavalid = force_rdv || (pend_cnt == 1);

  always @(posedge clock) begin
    if (bus.av_read && bus.av_waitrequest) wait_cnt <= wait_cnt + 1;
    else                                   wait_cnt <= 0;
    if (bus.av_read && !bus.av_waitrequest) begin
      pend_cnt  <= RDV_LAT;
      pend_addr <= bus.av_address;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          wait_n;
    logic        stuck;
    int          exp_lat;
    logic        exp_match;
    logic        exp_to;
    logic [31:0] exp_id;
    logic [31:0] exp_ts;
  } vec_t;

  vec_t vecs[7];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns cycles from the start cycle to the done pulse, -1 if none.
  task automatic wait_done(input int first_k, output int lat);
    lat = -1;
    if (done) lat = first_k;
    for (int k = first_k + 1; k <= 60 && lat < 0; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) lat = k;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    logic stable_ok, prev_hold, prev_addr;
    id_word = v.id_word; ts_word = v.ts_word; wait_n = v.wait_n; stuck = v.stuck;
    lat = -1; stable_ok = 1'b1; prev_hold = 1'b0; prev_addr = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (prev_hold && !done && (bus.av_read !== 1'b1 || bus.av_address !== prev_addr)) stable_ok = 1'b0;
      prev_hold = bus.av_read && bus.av_waitrequest;
      prev_addr = bus.av_address;
      if (done) lat = k;
    end
    check({v.name, " latency"},     32'(lat),          32'(v.exp_lat));
    check({v.name, " match"},       32'(match),        32'(v.exp_match));
    check({v.name, " timeout_err"}, 32'(timeout_err),  32'(v.exp_to));
    check({v.name, " id_value"},    id_value,          v.exp_id);
    check({v.name, " ts_value"},    timestamp_value,   v.exp_ts);
    check({v.name, " stall_stable"}, 32'(stable_ok),   32'd1);
    @(posedge clock);
    @(negedge clock);
    check({v.name, " done_one_cycle"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int lat, n_done, first_done;
    logic found;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset outputs", {26'd0, bus.av_read, bus.av_address, busy, done, match, timeout_err}, 32'd0);
    check("reset values", id_value | timestamp_value, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    vecs[0] = '{"nominal",      32'd0, EXP_TS,       0,      1'b0, LAT0,     1'b1, 1'b0, 32'd0, EXP_TS};
    vecs[1] = '{"bad_id",       32'd1, EXP_TS,       0,      1'b0, LAT0,     1'b0, 1'b0, 32'd1, EXP_TS};
    vecs[2] = '{"wait_mid",     32'd0, EXP_TS,       W_MID,  1'b0, LAT_MID,  1'b1, 1'b0, 32'd0, EXP_TS};
    vecs[3] = '{"bad_ts",       32'd0, 32'd12345,    1,      1'b0, LAT_ONE,  1'b0, 1'b0, 32'd0, 32'd12345};
    vecs[4] = '{"expiry_edge",  32'd0, EXP_TS,       W_EDGE, 1'b0, LAT_EDGE, 1'b1, 1'b0, 32'd0, EXP_TS};
    vecs[5] = '{"stuck",        32'd0, EXP_TS,       0,      1'b1, 9,        1'b0, 1'b1, 32'd0, 32'd0};
    vecs[6] = '{"bad_id_wait",  32'd1, EXP_TS,       W_LAST, 1'b0, LAT_LAST, 1'b0, 1'b0, 32'd1, EXP_TS};

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // New start clears latched words, then a stuck slave times out.
    stuck = 1'b1; wait_n = 0; id_word = 32'd0; ts_word = EXP_TS;
    pulse_start();
    check("start clears words", id_value | timestamp_value, 32'd0);
    check("busy after start", 32'(busy), 32'd1);
    wait_done(1, lat);
    check("stuck timeout latency", 32'(lat), 32'd9);
    check("stuck timeout_err/av_read", {30'd0, timeout_err, bus.av_read}, 32'd2);
    stuck = 1'b0;
    pulse_start();
    check("restart clears timeout_err", 32'(timeout_err), 32'd0);
    wait_done(1, lat);
    check("restart match", {30'd0, match, timeout_err}, 32'd2);

    // Stray readdatavalid while in DONE changes nothing.
    id_word = 32'hdead_beef; ts_word = 32'hcafe_f00d; force_rdv = 1'b1;
    repeat (3) @(negedge clock);
    force_rdv = 1'b0;
    check("stray rdv id", id_value, 32'd0);
    check("stray rdv ts", timestamp_value, EXP_TS);
    check("stray rdv flags", {29'd0, match, done, busy}, 32'd4);

    // A second start while busy must not restart or queue another run.
    id_word = 32'd0; ts_word = EXP_TS; wait_n = 0;
    pulse_start();
    @(posedge clock); @(negedge clock);
    start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    n_done = 0; first_done = -1;
    for (int k = 3; k <= 30; k++) begin
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      @(posedge clock); @(negedge clock);
    end
    check("busy start done count", 32'(n_done), 32'd1);
    check("busy start latency", 32'(first_done), 32'(LAT0));

    // Reset while the timestamp read is stalled.
    wait_n = W_MID;
    start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clock); @(negedge clock);
      start = 1'b0;
      if (bus.av_read && bus.av_address) found = 1'b1;
    end
    check("reached RD_TS", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("mid reset outputs", {26'd0, bus.av_read, bus.av_address, busy, done, match, timeout_err}, 32'd0);
    check("mid reset values", id_value | timestamp_value, 32'd0);
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); @(negedge clock);
      if (done || busy) n_done++;
      force_rdv = (k < 2);
    end
    force_rdv = 1'b0;
    check("no done after reset", 32'(n_done), 32'd0);
    check("idle rdv ignored", id_value | timestamp_value, 32'd0);

    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_read_master.md
Name: sysid_read_master

Overview:
- Avalon-MM read initiator for the system-ID slave's control port (1-bit word address, 32-bit readdata).
- On a start pulse it reads the ID word (address 0), then the timestamp word (address 1), and compares both against expected values.
- It reports match, mismatch or timeout to boot/health logic and latches both words for debug.

Parameters:
- EXPECTED_ID, 32'h0000_0000, required value at address 0.
- EXPECTED_TIMESTAMP, 32'd1683891951, required value at address 1.
- TIMEOUT_CYCLES, 256, maximum cycles per read transaction before abort; range 2..65535.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; ignored unless in IDLE or DONE.
- av_address  out  1  word address to the sysid slave.
- av_read  out  1  read strobe.
- av_waitrequest  in  1  slave stall; tie 0 for slaves without it.
- av_readdata  in  32  slave read data.
- av_readdatavalid  in  1  used only with SYSID_READDATAVALID_EN.
- id_value  out  32  latched address-0 word.
- timestamp_value  out  32  latched address-1 word.
- busy  out  1  high from accepted start until DONE.
- done  out  1  one-cycle pulse on completion (any result).
- match  out  1  sticky until next start: both words equal expected.
- timeout_err  out  1  sticky until next start: a transaction exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset mid-transaction drops av_read in the same edge and raises no done.
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, DONE.
- IDLE/DONE + start -> RD_ID next cycle. That edge clears match and timeout_err and zeroes id_value/timestamp_value; busy=1.
- RD_ID: av_read=1, av_address=0, held stable while av_waitrequest=1.
  - Without the macro: readdata is sampled in the cycle av_read && !av_waitrequest, latched into id_value -> RD_TS.
  - With the macro: acceptance -> WT_ID (av_read=0); av_readdatavalid latches id_value -> RD_TS.
- RD_TS/WT_TS: identical to RD_ID/WT_ID with av_address=1, latching timestamp_value -> CHECK.
- CHECK: match <= (id_value==EXPECTED_ID) && (timestamp_value==EXPECTED_TIMESTAMP) -> DONE.
- DONE: done=1 for exactly the entry cycle, busy=0; then remains in DONE. A start is accepted in any cycle of DONE, including the done-pulse cycle.
- Latency with no stalls and no macro: start at cycle N -> reads in N+1 and N+2, CHECK N+3, done N+4.
- Timeout: counter reloads on entry to each RD_* state and increments every cycle in RD_*/WT_*. On reaching TIMEOUT_CYCLES-1 without completion:
  - av_read drops, timeout_err=1, match=0, -> DONE (done pulses).
  - Data arriving in the same cycle as expiry wins: it is latched, with no timeout.
- Stray av_readdatavalid outside WT_* is ignored.
- start while busy is ignored, with no effect on the sequence.

Optional Feature:
- SYSID_READDATAVALID_EN, defined:
  - Pipelined variable-latency reads. WT_ID/WT_TS are used; data is taken only on av_readdatavalid.
  - One outstanding read at a time; the timeout spans request plus wait.
- Undefined:
  - Fixed zero-latency slave; WT_* states are unreachable and av_readdatavalid is unconnected internally.
  - The port still exists; it is ignored.

Decomposition:
- Package sysid_read_pkg:
  - state enum (3-bit);
  - SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1;
  - timeout counter width localparam derived via $clog2(TIMEOUT_CYCLES).
- One natural sub-module: sysid_timeout_ctr, with inputs load/enable and output expired, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Zero-wait slave returning 0 at addr0 and 1683891951 at addr1; pulse start -> done at start+4, match=1, timeout_err=0, id_value=0, timestamp_value=1683891951.
- Slave returns 32'h0000_0001 at addr0 -> done pulses, match=0, id_value=1, timeout_err=0.
- av_waitrequest held 3 cycles on each read -> av_address/av_read stable throughout, done at start+10, match=1.
- TIMEOUT_CYCLES=8, av_waitrequest stuck high:
  - expected: timeout_err=1 after 8 cycles in RD_ID, av_read=0, done pulses, match=0;
  - then a new start clears timeout_err.
- With SYSID_READDATAVALID_EN, readdatavalid 5 cycles after acceptance:
  - values latched correctly, match=1;
  - extra readdatavalid in IDLE causes no change.
- Reset asserted while in RD_TS -> next cycle all outputs 0, state IDLE, no done pulse; start during busy ignored.
